sys_stream_bridge: RTL and testbench

// - System-level bridge between the external testbench/memory side and top_chip; the successor to the plain system wrapper.
// - Adds a skid-buffered input handshake and a tagged output FIFO with downstream backpressure.
// - Adds a run-control FSM with a latched stride mode (adds step 8) and saturating bandwidth/cycle counters at the chip boundary.

---
 rtl/sys_bridge_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/sys_stream_bridge.sv | 176 +++++++++++++++++
 tb/tb_sys_stream_bridge.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bridge_pkg.sv
// Shared types for the system stream bridge: stride encoding and run-control states.
package sys_bridge_pkg;

   typedef enum logic [1:0] {
      STEP1 = 2'd0,
      STEP2 = 2'd1,
      STEP4 = 2'd2,
      STEP8 = 2'd3
   } stride_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      RUN    = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } bridge_state_e;

   localparam int unsigned SKID_DEPTH = 2;

   function automatic logic is_active(input bridge_state_e st);
      return (st == LAUNCH) || (st == RUN) || (st == DRAIN);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push on a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop_i & (count_q != '0);
   assign do_push = push_i & ((count_q != CNT_MAX) | do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CNT_MAX);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/sys_stream_bridge.sv
// Bridge between the external stream/memory side and top_chip: skid-buffered input,
// tagged output FIFO, run-control FSM and saturating statistics counters.
module sys_stream_bridge
   import sys_bridge_pkg::*;
#(
   parameter int unsigned IO_DATA_WIDTH      = 16,
   parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
   parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
   parameter int unsigned OUTPUT_NB_CHANNELS = 64,
   parameter int unsigned OUT_FIFO_DEPTH     = 8,
   parameter int unsigned CNT_WIDTH          = 32,
   localparam int unsigned XW = $clog2(FEATURE_MAP_WIDTH),
   localparam int unsigned YW = $clog2(FEATURE_MAP_HEIGHT),
   localparam int unsigned CW = $clog2(OUTPUT_NB_CHANNELS)
) (
   input  logic                     clk,
   input  logic                     rst_in,
   input  logic                     start,
   input  logic [1:0]               conv_stride_mode,
   input  logic [IO_DATA_WIDTH-1:0] s_a_data,
   input  logic [IO_DATA_WIDTH-1:0] s_b_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [IO_DATA_WIDTH-1:0] c_a_data,
   output logic [IO_DATA_WIDTH-1:0] c_b_data,
   output logic                     c_valid,
   input  logic                     c_ready,
   output logic [1:0]               c_stride_mode,
   output logic                     c_start,
   input  logic                     c_running,
   input  logic [IO_DATA_WIDTH-1:0] c_out,
   input  logic                     c_out_valid,
   input  logic [XW-1:0]            c_out_x,
   input  logic [YW-1:0]            c_out_y,
   input  logic [CW-1:0]            c_out_ch,
   output logic [IO_DATA_WIDTH-1:0] m_data,
   output logic [XW-1:0]            m_x,
   output logic [YW-1:0]            m_y,
   output logic [CW-1:0]            m_ch,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic [CNT_WIDTH-1:0]     in_beats,
   output logic [CNT_WIDTH-1:0]     out_beats,
   output logic [CNT_WIDTH-1:0]     run_cycles
);
   typedef struct packed {
      logic [IO_DATA_WIDTH-1:0] data;
      logic [XW-1:0]            x;
      logic [YW-1:0]            y;
      logic [CW-1:0]            ch;
   } out_tag_t;

   localparam int unsigned OAW = $clog2(OUT_FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   bridge_state_e state_q, state_d;
   stride_e       stride_q;
   logic          overflow_q;
   logic [CNT_WIDTH-1:0] in_beats_q, out_beats_q, run_cycles_q;

   logic start_acc, active;
   logic skid_push, skid_pop, skid_full, skid_empty;
   logic [1:0] skid_count;
   logic [2*IO_DATA_WIDTH-1:0] skid_dout;
   logic out_push, out_pop, out_full, out_empty, out_drop;
   logic [OAW:0] out_count;
   out_tag_t out_din, out_dout;

   assign start_acc = (state_q == IDLE) & start;
   assign active    = (state_q != IDLE);

   // Input skid: s_ready only depends on registered state, so the pair sustains one beat per cycle.
   assign s_ready   = (state_q == RUN) & ~skid_full;
   assign skid_push = s_valid & s_ready;
   assign c_valid   = (skid_count != 2'd0);
   assign skid_pop  = c_valid & c_ready;
   assign {c_a_data, c_b_data} = skid_dout;

   sync_fifo #(.WIDTH(2 * IO_DATA_WIDTH), .DEPTH(SKID_DEPTH)) u_skid (
      .clk_i   (clk),
      .rst_i   (rst_in),
      .push_i  (skid_push),
      .data_i  ({s_a_data, s_b_data}),
      .pop_i   (skid_pop),
      .data_o  (skid_dout),
      .full_o  (skid_full),
      .empty_o (skid_empty),
      .count_o (skid_count)
   );

   assign out_din  = '{data: c_out, x: c_out_x, y: c_out_y, ch: c_out_ch};
   assign m_valid  = (out_count != '0);
   assign out_pop  = m_valid & m_ready;
   assign out_push = c_out_valid & active & (~out_full | out_pop);
   assign out_drop = c_out_valid & active & out_full & ~out_pop;
   assign m_data   = out_dout.data;
   assign m_x      = out_dout.x;
   assign m_y      = out_dout.y;
   assign m_ch     = out_dout.ch;

   sync_fifo #(.WIDTH($bits(out_tag_t)), .DEPTH(OUT_FIFO_DEPTH)) u_out_fifo (
      .clk_i   (clk),
      .rst_i   (rst_in),
      .push_i  (out_push),
      .data_i  (out_din),
      .pop_i   (out_pop),
      .data_o  (out_dout),
      .full_o  (out_full),
      .empty_o (out_empty),
      .count_o (out_count)
   );

   always_ff @(posedge clk) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LAUNCH; else state_d = IDLE;
         LAUNCH:  state_d = RUN;
         RUN:     if (!c_running) state_d = DRAIN; else state_d = RUN;
         DRAIN:   if (skid_empty && out_empty) state_d = DONE; else state_d = DRAIN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      c_start = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE:    busy = 1'b0;
         LAUNCH:  begin c_start = 1'b1; busy = 1'b1; end
         RUN:     busy = 1'b1;
         DRAIN:   busy = 1'b1;
         DONE:    begin done = 1'b1; busy = 1'b1; end
         default: busy = 1'b0;
      endcase
   end

   // Stride, sticky overflow and saturating counters; all restart on an accepted start.
   always_ff @(posedge clk) begin
      if (rst_in) begin
         stride_q     <= STEP1;
         overflow_q   <= 1'b0;
         in_beats_q   <= '0;
         out_beats_q  <= '0;
         run_cycles_q <= '0;
      end else if (start_acc) begin
         stride_q     <= stride_e'(conv_stride_mode);
         overflow_q   <= 1'b0;
         in_beats_q   <= '0;
         out_beats_q  <= '0;
         run_cycles_q <= '0;
      end else begin
         if (out_drop) overflow_q <= 1'b1;
         if (skid_pop && in_beats_q != CNT_MAX) in_beats_q <= in_beats_q + CNT_ONE;
         if (out_push && out_beats_q != CNT_MAX) out_beats_q <= out_beats_q + CNT_ONE;
         if (is_active(state_q) && run_cycles_q != CNT_MAX) run_cycles_q <= run_cycles_q + CNT_ONE;
      end
   end

   assign c_stride_mode = stride_q;
   assign overflow      = overflow_q;
   assign in_beats      = in_beats_q;
   assign out_beats     = out_beats_q;
   assign run_cycles    = run_cycles_q;

endmodule

// File: tb/tb_sys_stream_bridge.sv
// Directed bench for sys_stream_bridge; a second instance with 4-bit counters checks saturation.
module tb_sys_stream_bridge;
   logic clk = 1'b0;
   logic rst_in, start, s_valid, c_ready, c_running, c_out_valid, m_ready;
   logic [1:0] conv_stride_mode;
   logic [15:0] s_a_data, s_b_data, c_out;
   logic [9:0] c_out_x, c_out_y;
   logic [5:0] c_out_ch;

   logic d0_s_ready, d0_c_valid, d0_c_start, d0_m_valid, d0_busy, d0_done, d0_overflow;
   logic [15:0] d0_c_a_data, d0_c_b_data, d0_m_data;
   logic [1:0] d0_c_stride_mode;
   logic [9:0] d0_m_x, d0_m_y;
   logic [5:0] d0_m_ch;
   logic [31:0] d0_in_beats, d0_out_beats, d0_run_cycles;

   logic d1_s_ready, d1_c_valid, d1_c_start, d1_m_valid, d1_busy, d1_done, d1_overflow;
   logic [15:0] d1_c_a_data, d1_c_b_data, d1_m_data;
   logic [1:0] d1_c_stride_mode;
   logic [9:0] d1_m_x, d1_m_y;
   logic [5:0] d1_m_ch;
   logic [3:0] d1_in_beats, d1_out_beats, d1_run_cycles;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int mode_err = 0;
   logic [1:0] exp_mode = 2'd0;
   logic full_seen = 1'b0;
   logic tog_en = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];

   always #5 clk = ~clk;

   sys_stream_bridge dut0 (
      .clk(clk), .rst_in(rst_in), .start(start), .conv_stride_mode(conv_stride_mode),
      .s_a_data(s_a_data), .s_b_data(s_b_data), .s_valid(s_valid), .s_ready(d0_s_ready),
      .c_a_data(d0_c_a_data), .c_b_data(d0_c_b_data), .c_valid(d0_c_valid), .c_ready(c_ready),
      .c_stride_mode(d0_c_stride_mode), .c_start(d0_c_start), .c_running(c_running),
      .c_out(c_out), .c_out_valid(c_out_valid), .c_out_x(c_out_x), .c_out_y(c_out_y),
      .c_out_ch(c_out_ch), .m_data(d0_m_data), .m_x(d0_m_x), .m_y(d0_m_y), .m_ch(d0_m_ch),
      .m_valid(d0_m_valid), .m_ready(m_ready), .busy(d0_busy), .done(d0_done),
      .overflow(d0_overflow), .in_beats(d0_in_beats), .out_beats(d0_out_beats),
      .run_cycles(d0_run_cycles)
   );

   sys_stream_bridge #(.CNT_WIDTH(4)) dut1 (
      .clk(clk), .rst_in(rst_in), .start(start), .conv_stride_mode(conv_stride_mode),
      .s_a_data(s_a_data), .s_b_data(s_b_data), .s_valid(s_valid), .s_ready(d1_s_ready),
      .c_a_data(d1_c_a_data), .c_b_data(d1_c_b_data), .c_valid(d1_c_valid), .c_ready(c_ready),
      .c_stride_mode(d1_c_stride_mode), .c_start(d1_c_start), .c_running(c_running),
      .c_out(c_out), .c_out_valid(c_out_valid), .c_out_x(c_out_x), .c_out_y(c_out_y),
      .c_out_ch(c_out_ch), .m_data(d1_m_data), .m_x(d1_m_x), .m_y(d1_m_y), .m_ch(d1_m_ch),
      .m_valid(d1_m_valid), .m_ready(m_ready), .busy(d1_busy), .done(d1_done),
      .overflow(d1_overflow), .in_beats(d1_in_beats), .out_beats(d1_out_beats),
      .run_cycles(d1_run_cycles)
   );

   // Edge monitor: forwarded beats, done pulses, stride stability, skid back-pressure.
   always @(posedge clk) begin
      if (d0_c_valid && c_ready) got_q.push_back({d0_c_a_data, d0_c_b_data});
      if (d0_done) done_cnt++;
      if (d0_busy && d0_c_stride_mode != exp_mode) mode_err++;
      if (s_valid && !d0_s_ready && d0_busy && c_running) full_seen = 1'b1;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (tog_en) c_ready = ~c_ready;
   endtask

   task automatic start_run(input logic [1:0] mode);
      start = 1'b1; conv_stride_mode = mode; c_running = 1'b1; exp_mode = mode;
      tick();
      start = 1'b0; conv_stride_mode = ~mode;
      check_val("launch_cstart", {63'd0, d0_c_start}, 64'd1);
      tick();
   endtask

   task automatic end_run();
      int guard;
      c_running = 1'b0;
      guard = 0;
      do begin
         tick();
         guard++;
      end while (d0_busy && guard < 60);
      check_val("end_busy", {63'd0, d0_busy}, 64'd0);
   endtask

   task automatic send_beats(input int n, input logic [15:0] base);
      int guard;
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_a_data = base + 16'(i);
         s_b_data = ~(base + 16'(i));
         guard = 0;
         while (!d0_s_ready && guard < 20) begin
            tick();
            guard++;
         end
         if (guard >= 20) check_val("s_ready_timeout", 64'd0, 64'd1);
         exp_q.push_back({s_a_data, s_b_data});
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic check_stream(input string tag);
      check_val({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_val({tag, "_beat"}, {32'd0, got_q[i]}, {32'd0, exp_q[i]});
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic push_result(input logic [15:0] d, input int i);
      c_out_valid = 1'b1; c_out = d;
      c_out_x = 10'(i); c_out_y = 10'(2 * i); c_out_ch = 6'(i);
   endtask

   task automatic drain_results(input string tag, input logic [15:0] exp_d [8], input int exp_i [8]);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_val({tag, "_mvalid"}, {63'd0, d0_m_valid}, 64'd1);
         check_val({tag, "_mdata"}, {48'd0, d0_m_data}, {48'd0, exp_d[i]});
         check_val({tag, "_mtag"}, {42'd0, d0_m_x, d0_m_y, d0_m_ch},
                   {42'd0, 10'(exp_i[i]), 10'(2 * exp_i[i]), 6'(exp_i[i])});
         tick();
      end
      check_val({tag, "_empty"}, {63'd0, d0_m_valid}, 64'd0);
      m_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] ed [8];
      int ei [8];
      int d_before;

      rst_in = 1'b1; start = 1'b1; conv_stride_mode = 2'd3; s_valid = 1'b0;
      s_a_data = '0; s_b_data = '0; c_ready = 1'b1; c_running = 1'b0;
      c_out_valid = 1'b0; c_out = '0; c_out_x = '0; c_out_y = '0; c_out_ch = '0; m_ready = 1'b0;

      // 1: reset, start held during reset is ignored
      repeat (3) tick();
      check_val("rst_outs", {d0_s_ready, d0_c_valid, d0_m_valid, d0_busy, d0_done,
                              d0_overflow, d0_c_start, d0_c_stride_mode}, 64'd0);
      check_val("rst_cnts", {d0_in_beats, d0_out_beats}, 64'd0);
      check_val("rst_data", {16'd0, d0_run_cycles, d0_m_data}, 64'd0);
      rst_in = 1'b0; start = 1'b0;
      tick();
      check_val("rst_busy_after", {63'd0, d0_busy}, 64'd0);

      // 2: streaming with stride mode 3
      d_before = done_cnt;
      start_run(2'd3);
      check_val("run_sready", {63'd0, d0_s_ready}, 64'd1);
      send_beats(16, 16'h0100);
      repeat (2) tick();
      end_run();
      check_stream("stream");
      check_val("stream_in_beats", {32'd0, d0_in_beats}, 64'd16);
      check_val("stream_in_sat", {60'd0, d1_in_beats}, 64'd15);
      check_val("stream_run_cycles", {32'd0, d0_run_cycles}, 64'd21);
      check_val("stream_cyc_sat", {60'd0, d1_run_cycles}, 64'd15);
      check_val("stream_done_once", 64'(done_cnt - d_before), 64'd1);
      check_val("stream_mode_const", 64'(mode_err), 64'd0);

      // 3: downstream chip back-pressure
      start_run(2'd1);
      full_seen = 1'b0;
      tog_en = 1'b1;
      send_beats(8, 16'h0200);
      tog_en = 1'b0; c_ready = 1'b1;
      repeat (3) tick();
      end_run();
      check_stream("bp");
      check_val("bp_skid_full_seen", {63'd0, full_seen}, 64'd1);
      check_val("bp_in_beats", {32'd0, d0_in_beats}, 64'd8);

      // 4: overflow on a full output FIFO
      start_run(2'd2);
      check_val("ovf_mvalid_pre", {63'd0, d0_m_valid}, 64'd0);
      for (int i = 0; i < 9; i++) begin
         push_result(16'hA000 + 16'(i), i);
         tick();
         if (i == 0) check_val("ovf_wr_latency", {63'd0, d0_m_valid}, 64'd1);
      end
      c_out_valid = 1'b0;
      check_val("ovf_flag", {63'd0, d0_overflow}, 64'd1);
      check_val("ovf_out_beats", {32'd0, d0_out_beats}, 64'd8);
      for (int i = 0; i < 8; i++) begin ed[i] = 16'hA000 + 16'(i); ei[i] = i; end
      drain_results("ovf", ed, ei);
      end_run();

      // 5: write on a full FIFO with a pop in the same cycle
      start_run(2'd0);
      for (int i = 0; i < 8; i++) begin
         push_result(16'hB000 + 16'(i), i);
         tick();
      end
      push_result(16'hB008, 8);
      m_ready = 1'b1;
      tick();
      c_out_valid = 1'b0; m_ready = 1'b0;
      check_val("fp_overflow", {63'd0, d0_overflow}, 64'd0);
      check_val("fp_out_beats", {32'd0, d0_out_beats}, 64'd9);
      for (int i = 0; i < 8; i++) begin ed[i] = 16'hB001 + 16'(i); ei[i] = i + 1; end
      drain_results("fp", ed, ei);
      end_run();

      // 6: counter saturation, then reset mid-run
      start_run(2'd3);
      send_beats(20, 16'h0300);
      repeat (2) tick();
      check_val("sat_in_beats_wide", {32'd0, d0_in_beats}, 64'd20);
      check_val("sat_in_beats", {60'd0, d1_in_beats}, 64'd15);
      check_stream("sat");
      d_before = done_cnt;
      rst_in = 1'b1;
      tick();
      check_val("abort_busy", {62'd0, d0_busy, d1_busy}, 64'd0);
      check_val("abort_outs", {61'd0, d0_s_ready, d0_c_valid, d0_m_valid}, 64'd0);
      check_val("abort_cnt", {32'd0, d0_in_beats}, 64'd0);
      rst_in = 1'b0;
      repeat (2) tick();
      check_val("abort_no_done", 64'(done_cnt - d_before), 64'd0);
      check_val("abort_idle", {63'd0, d0_busy}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
